mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store unit directly downstream of the core control FSM.
- Accepts one access per Execute pulse, during FETCH or MEMORY.
- Checks alignment, then steers bytes onto a word-wide handshake bus to instruction/data RAM.
- Returns sign/zero-extended load data with level Ready / DataReady / Misalignment status, which the control FSM polls.

Parameters:
- ADDR_W, 32: byte address width; the bus word address is ADDR_W-2 bits.
- TIMEOUT, 255: maximum cycles MemReq may wait for MemAck before aborting with BusError; range 1..65535.

Ports:
- Clk  in  1  single clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Execute  in  1  access request; accepted only when Ready=1.
- WriteEn  in  1  1=store, 0=load; sampled with Execute.
- Addr  in  ADDR_W  byte address; sampled with Execute.
- WData  in  32  store data, right-aligned; sampled with Execute.
- Size  in  2  00=byte, 01=half, 10=word, 11=treated as word.
- Unsigned  in  1  1=zero-extend load, 0=sign-extend.
- Ready  out  1  unit idle and can accept Execute.
- DataReady  out  1  access completed without error; held high until the next accepted Execute.
- RData  out  32  extended load data; valid while DataReady=1 after a load.
- Misalignment  out  1  last accepted access was misaligned; held until the next accepted Execute.
- BusError  out  1  last access timed out; held until the next accepted Execute.
- MemReq  out  1  bus request; held high until MemAck.
- MemWe  out  1  bus write strobe.
- MemAddr  out  ADDR_W-2  word address, Addr[ADDR_W-1:2].
- MemBe  out  4  byte enables.
- MemWData  out  32  lane-steered store data.
- MemRData  in  32  bus read data; valid in the MemAck cycle.
- MemAck  in  1  bus completion; ignored when MemReq=0.

Behaviour:
- Reset (ResetN=0, asynchronous): state IDLE, Ready=1, all other outputs 0, timeout counter 0.
  - Reset mid-transaction drops MemReq immediately.
  - The pending access is discarded; no DataReady follows.
- FSM states:
  - IDLE: Ready=1.
  - REQ: MemReq=1, Ready=0.
  - DONE: one cycle, Ready=0; result is registered.
- IDLE, Execute=1 at edge N:
  - Clear DataReady, Misalignment, BusError; latch WriteEn, Addr, Size, Unsigned, Addr[1:0].
  - Misaligned (half with Addr[0]=1; word with Addr[1:0]!=0): set Misalignment at N+1 and stay IDLE. No bus cycle, MemBe=0. Ready stays 1.
  - Otherwise: go to REQ at N+1 with MemReq, MemWe, MemAddr, MemBe, MemWData registered and stable for the whole REQ.
- Byte enables:
  - byte: 1<<Addr[1:0].
  - half: 0011 or 1100 by Addr[1].
  - word: 1111.
- Store data: WData replicated across lanes (byte in every lane, half in both halves).
- REQ, MemAck=1 at edge M:
  - Capture MemRData; deassert MemReq at M+1; enter DONE.
  - Zero-wait ack (first REQ cycle) is legal.
- DONE:
  - For a load, RData gets the selected lane, sign/zero-extended per Size/Unsigned. A store leaves RData unchanged.
  - DataReady=1 and state IDLE at the following edge, so Ready returns 2 cycles after MemAck.
- Timeout: the counter increments each REQ cycle without MemAck. When it reaches TIMEOUT:
  - Drop MemReq, set BusError, go IDLE; DataReady stays 0.
  - A MemAck arriving in the same cycle as expiry wins; that access completes normally.
- Execute while Ready=0 is ignored; no queuing.
- Latency for an aligned access, Execute to DataReady: 3 cycles with a zero-wait bus.

Decomposition:
- Shared package riscv_mem_pkg:
  - Size encodings SIZE_BYTE/HALF/WORD.
  - FSM state constants IDLE/REQ/DONE.
  - Default TIMEOUT.
- Sub-module mem_lane_align (purely combinational), shared with future cache logic:
  - Store side: MemBe/MemWData from Size, Addr[1:0], WData.
  - Load side: extended RData from MemRData, Size, Addr[1:0], Unsigned.

Test Plan:
- Word load: Addr=0x100, Size=10, bus acks 2 cycles after MemReq with MemRData=0xDEADBEEF → MemAddr=0x40, MemBe=1111, MemWe=0; RData=0xDEADBEEF with DataReady=1; Ready returns 2 cycles after MemAck.
- Byte load signed/unsigned: Addr=0x103, MemRData=0x80123456 → MemBe=1000; RData=0xFFFFFF80 signed, 0x00000080 unsigned.
- Half store: Addr=0x202, WData=0x0000ABCD → MemWe=1, MemBe=1100, MemWData=0xABCDABCD; DataReady=1 after ack, RData unchanged.
- Misaligned word load: Addr=0x101 → Misalignment=1 next cycle, MemReq never asserted, Ready=1 throughout; the next aligned Execute clears Misalignment.
- Timeout: TIMEOUT=4, MemAck held 0 → MemReq high exactly 4 cycles, then BusError=1, DataReady=0, Ready=1. Repeat with MemAck in the expiry cycle → normal completion, BusError=0.
- Async reset in REQ: ResetN low mid-cycle → MemReq=0 immediately; after release, Ready=1, DataReady=0, and a fresh access completes normally.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared load/store definitions: size codes,
// control states and the alignment rule.
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Size 2'b11 falls into the word rule.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (size == SIZE_BYTE): m = 1'b0;
      (size == SIZE_HALF): m = lo[0];
      default:             m = |lo;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide request/acknowledge bus between
// the load/store unit and instruction/data RAM.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-3:0] MemAddr;
  logic [3:0]        MemBe;
  logic [31:0]       MemWData;
  logic [31:0]       MemRData;
  logic              MemAck;

  modport master (
    output MemReq, MemWe, MemAddr,
    output MemBe, MemWData,
    input  MemRData, MemAck
  );

  modport slave (
    input  MemReq, MemWe, MemAddr,
    input  MemBe, MemWData,
    output MemRData, MemAck
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication
// and load lane select with sign/zero extension.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    unique case (1'b1)
      (st_size == SIZE_BYTE): begin
        mem_be    = 4'b0001 << st_lo;
        mem_wdata = {4{st_wdata[7:0]}};
      end
      (st_size == SIZE_HALF): begin
        mem_be    = st_lo[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{st_wdata[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = st_wdata;
      end
    endcase
  end

  always_comb begin
    b     = mem_rdata[{ld_lo, 3'b000} +: 8];
    h     = ld_lo[1] ? mem_rdata[31:16]
                     : mem_rdata[15:0];
    sx    = ~ld_unsigned;
    rdata = mem_rdata;
    unique case (1'b1)
      (ld_size == SIZE_BYTE):
        rdata = {{24{sx & b[7]}}, b};
      (ld_size == SIZE_HALF):
        rdata = {{16{sx & h[15]}}, h};
      default:
        rdata = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: alignment check, one bus
// transaction per accepted Execute, with timeout.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              Execute,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WData,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  output logic              Ready,
  output logic              DataReady,
  output logic [31:0]       RData,
  output logic              Misalignment,
  output logic              BusError,
  mem_access_unit_if.master bus
);

  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lo_q, lo_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       rcap_q, rcap_d;
  logic              ready_q, ready_d;
  logic              drdy_q, drdy_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;
  logic              req_q, req_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-3:0] maddr_q, maddr_d;
  logic [3:0]        mbe_q, mbe_d;
  logic [31:0]       mwd_q, mwd_d;

  logic [3:0]        st_be;
  logic [31:0]       st_wd;
  logic [31:0]       ld_rd;

  mem_lane_align u_align (
    .st_size     (Size),
    .st_lo       (Addr[1:0]),
    .st_wdata    (WData),
    .mem_be      (st_be),
    .mem_wdata   (st_wd),
    .ld_size     (size_q),
    .ld_lo       (lo_q),
    .ld_unsigned (uns_q),
    .mem_rdata   (rcap_q),
    .rdata       (ld_rd)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    rcap_d  = rcap_q;
    ready_d = ready_q;
    drdy_d  = drdy_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    berr_d  = berr_q;
    req_d   = req_q;
    mwe_d   = mwe_q;
    maddr_d = maddr_q;
    mbe_d   = mbe_q;
    mwd_d   = mwd_q;
    unique case (state_q)
      IDLE: begin
        if (Execute) begin
          drdy_d = 1'b0;
          mis_d  = 1'b0;
          berr_d = 1'b0;
          we_d   = WriteEn;
          size_d = Size;
          uns_d  = Unsigned;
          lo_d   = Addr[1:0];
          cnt_d  = 16'd0;
          if (misaligned(Size, Addr[1:0])) begin
            mis_d = 1'b1;
          end else begin
            state_d = REQ;
            ready_d = 1'b0;
            req_d   = 1'b1;
            mwe_d   = WriteEn;
            maddr_d = Addr[ADDR_W-1:2];
            mbe_d   = st_be;
            mwd_d   = st_wd;
          end
        end
      end
      REQ: begin
        // An ack in the expiry cycle takes priority.
        if (bus.MemAck || cnt_q + 16'd1 == TO) begin
          req_d   = 1'b0;
          mwe_d   = 1'b0;
          maddr_d = '0;
          mbe_d   = 4'b0000;
          mwd_d   = 32'h0;
        end
        if (bus.MemAck) begin
          rcap_d  = bus.MemRData;
          state_d = DONE;
        end else if (cnt_q + 16'd1 == TO) begin
          state_d = IDLE;
          ready_d = 1'b1;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        drdy_d  = 1'b1;
        if (!we_q) rdata_d = ld_rd;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lo_q    <= 2'b00;
      cnt_q   <= 16'd0;
      rcap_q  <= 32'h0;
      ready_q <= 1'b1;
      drdy_q  <= 1'b0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      req_q   <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mbe_q   <= 4'b0000;
      mwd_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      rcap_q  <= rcap_d;
      ready_q <= ready_d;
      drdy_q  <= drdy_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      req_q   <= req_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      mbe_q   <= mbe_d;
      mwd_q   <= mwd_d;
    end
  end

  assign Ready        = ready_q;
  assign DataReady    = drdy_q;
  assign RData        = rdata_q;
  assign Misalignment = mis_q;
  assign BusError     = berr_q;
  assign bus.MemReq   = req_q;
  assign bus.MemWe    = mwe_q;
  assign bus.MemAddr  = maddr_q;
  assign bus.MemBe    = mbe_q;
  assign bus.MemWData = mwd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table,
// reset-in-flight sequence, randomized accesses.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic        Execute = 1'b0;
  logic        WriteEn = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WData = 32'h0;
  logic [1:0]  Size = 2'b00;
  logic        Unsigned = 1'b0;
  logic        Ready;
  logic        DataReady;
  logic [31:0] RData;
  logic        Misalignment;
  logic        BusError;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(
    .ADDR_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .Clk          (Clk),
    .ResetN       (ResetN),
    .Execute      (Execute),
    .WriteEn      (WriteEn),
    .Addr         (Addr),
    .WData        (WData),
    .Size         (Size),
    .Unsigned     (Unsigned),
    .Ready        (Ready),
    .DataReady    (DataReady),
    .RData        (RData),
    .Misalignment (Misalignment),
    .BusError     (BusError),
    .bus          (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        uns;
    int          dly;
    logic [31:0] bus_d;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
  } vec_t;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] last_rd = 32'h0;
  vec_t        tbl[12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [31:0] addr,
    input logic [31:0] wd, input logic [1:0] sz,
    input logic uns, input int dly,
    input logic [31:0] bus_d, input logic mis,
    input logic [3:0] be, input logic [31:0] mwd,
    input logic [31:0] rd);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd;
    v.sz = sz; v.uns = uns; v.dly = dly;
    v.bus_d = bus_d; v.mis = mis; v.be = be;
    v.mwd = mwd; v.rd = rd;
    return v;
  endfunction

  // Reference: access width in bytes drives every rule.
  function automatic vec_t model(input vec_t v);
    int          w;
    int          lo;
    logic [31:0] val;
    logic [31:0] mask;
    w  = (v.sz == 2'b00) ? 1 :
         (v.sz == 2'b01) ? 2 : 4;
    lo = int'(v.addr % 4);
    v.mis = (lo % w) != 0;
    v.be  = v.mis ? 4'b0000
                  : 4'((1 << w) - 1) << lo;
    for (int i = 0; i < 4; i++)
      v.mwd[8*i +: 8] = v.wd[8*(i % w) +: 8];
    val  = v.bus_d >> (8 * lo);
    mask = (w == 4) ? 32'hFFFF_FFFF
                    : (32'd1 << (8 * w)) - 32'd1;
    val  = val & mask;
    if (!v.uns && w < 4 && val[8*w-1])
      val = val | ~mask;
    v.rd = val;
    return v;
  endfunction

  task automatic access(input vec_t v);
    int n;
    bit acked;
    n = 0;
    while (!Ready && n < 10) begin
      @(negedge Clk);
      n++;
    end
    chk("ready_idle", 32'(Ready), 1);
    Execute  = 1'b1;
    WriteEn  = v.we;
    Addr     = v.addr;
    WData    = v.wd;
    Size     = v.sz;
    Unsigned = v.uns;
    @(negedge Clk);
    Execute = 1'b0;
    chk("misalign", 32'(Misalignment), 32'(v.mis));
    chk("drdy_clr", 32'(DataReady), 0);
    chk("berr_clr", 32'(BusError), 0);
    if (v.mis) begin
      chk("mis_ready", 32'(Ready), 1);
      chk("mis_req", 32'(bus.MemReq), 0);
      chk("mis_be", 32'(bus.MemBe), 0);
      return;
    end
    chk("req", 32'(bus.MemReq), 1);
    chk("req_ready", 32'(Ready), 0);
    chk("addr", 32'(bus.MemAddr), 32'(v.addr[31:2]));
    chk("be", 32'(bus.MemBe), 32'(v.be));
    chk("we", 32'(bus.MemWe), 32'(v.we));
    if (v.we) chk("wdata", bus.MemWData, v.mwd);
    n = 0;
    acked = 1'b0;
    while (!acked && n < TO) begin
      if (n == v.dly) begin
        bus.MemAck   = 1'b1;
        bus.MemRData = v.bus_d;
      end else begin
        bus.MemRData = $urandom;
      end
      // Execute while busy must be ignored.
      if (n == 0 && v.dly >= 2) begin
        Execute = 1'b1;
        Addr    = v.addr ^ 32'h40;
      end
      @(negedge Clk);
      Execute    = 1'b0;
      bus.MemAck = 1'b0;
      acked = (n == v.dly);
      if (!acked) begin
        n++;
        if (n < TO) begin
          chk("req_hold", 32'(bus.MemReq), 1);
          chk("addr_hold", 32'(bus.MemAddr),
              32'(v.addr[31:2]));
          chk("be_hold", 32'(bus.MemBe), 32'(v.be));
        end
      end
    end
    if (acked) begin
      chk("done_req", 32'(bus.MemReq), 0);
      chk("done_ready", 32'(Ready), 0);
      chk("done_drdy", 32'(DataReady), 0);
      @(negedge Clk);
      chk("ready_back", 32'(Ready), 1);
      chk("drdy", 32'(DataReady), 1);
      chk("berr", 32'(BusError), 0);
      if (!v.we) last_rd = v.rd;
      chk("rdata", RData, last_rd);
    end else begin
      chk("to_req", 32'(bus.MemReq), 0);
      chk("to_berr", 32'(BusError), 1);
      chk("to_drdy", 32'(DataReady), 0);
      chk("to_ready", 32'(Ready), 1);
      chk("to_rdata", RData, last_rd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bus.MemAck   = 1'b0;
    bus.MemRData = 32'h0;

    tbl[0]  = mk(0, 32'h100, 0, 2'b10, 0, 1,
                 32'hDEADBEEF, 0, 4'hF, 0, 32'hDEADBEEF);
    tbl[1]  = mk(0, 32'h103, 0, 2'b00, 0, 0,
                 32'h80123456, 0, 4'h8, 0, 32'hFFFFFF80);
    tbl[2]  = mk(0, 32'h103, 0, 2'b00, 1, 2,
                 32'h80123456, 0, 4'h8, 0, 32'h00000080);
    tbl[3]  = mk(1, 32'h202, 32'h0000ABCD, 2'b01, 0, 0,
                 32'h0, 0, 4'hC, 32'hABCDABCD, 0);
    tbl[4]  = mk(0, 32'h101, 0, 2'b10, 0, 0,
                 32'h0, 1, 4'h0, 0, 0);
    tbl[5]  = mk(0, 32'h102, 0, 2'b01, 0, 2,
                 32'h80010000, 0, 4'hC, 0, 32'hFFFF8001);
    tbl[6]  = mk(0, 32'h300, 0, 2'b10, 0, 9,
                 32'h0, 0, 4'hF, 0, 0);
    tbl[7]  = mk(0, 32'h304, 0, 2'b10, 0, 3,
                 32'h12345678, 0, 4'hF, 0, 32'h12345678);
    tbl[8]  = mk(0, 32'h105, 0, 2'b01, 0, 0,
                 32'h0, 1, 4'h0, 0, 0);
    tbl[9]  = mk(0, 32'h008, 0, 2'b11, 0, 1,
                 32'hCAFEF00D, 0, 4'hF, 0, 32'hCAFEF00D);
    tbl[10] = mk(1, 32'h001, 32'h000000A5, 2'b00, 0, 1,
                 32'h0, 0, 4'h2, 32'hA5A5A5A5, 0);
    tbl[11] = mk(0, 32'h102, 0, 2'b01, 1, 0,
                 32'h80010000, 0, 4'hC, 0, 32'h00008001);

    repeat (2) @(negedge Clk);
    chk("rst_ready", 32'(Ready), 1);
    chk("rst_drdy", 32'(DataReady), 0);
    chk("rst_mis", 32'(Misalignment), 0);
    chk("rst_berr", 32'(BusError), 0);
    chk("rst_req", 32'(bus.MemReq), 0);
    chk("rst_be", 32'(bus.MemBe), 0);
    chk("rst_rdata", RData, 0);
    ResetN = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 12; i++) access(tbl[i]);

    // Reset in the middle of a request.
    Execute  = 1'b1;
    WriteEn  = 1'b0;
    Addr     = 32'h400;
    Size     = 2'b10;
    Unsigned = 1'b0;
    @(negedge Clk);
    Execute = 1'b0;
    chk("pre_rst_req", 32'(bus.MemReq), 1);
    @(posedge Clk);
    #2 ResetN = 1'b0;
    #1;
    chk("rst_req_drop", 32'(bus.MemReq), 0);
    chk("rst_mid_ready", 32'(Ready), 1);
    chk("rst_mid_drdy", 32'(DataReady), 0);
    @(negedge Clk);
    ResetN  = 1'b1;
    last_rd = 32'h0;
    bus.MemAck   = 1'b1;
    bus.MemRData = 32'h5555AAAA;
    repeat (2) @(negedge Clk);
    bus.MemAck = 1'b0;
    chk("post_rst_drdy", 32'(DataReady), 0);
    chk("post_rst_ready", 32'(Ready), 1);
    chk("post_rst_req", 32'(bus.MemReq), 0);
    chk("post_rst_rdata", RData, 0);
    access(tbl[0]);

    for (int i = 0; i < 60; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.addr  = $urandom & 32'h0000_FFFF;
      v.wd    = $urandom;
      v.sz    = 2'($urandom_range(0, 3));
      v.uns   = 1'($urandom_range(0, 1));
      v.dly   = int'($urandom_range(0, 5));
      v.bus_d = $urandom;
      access(model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
